// File: rtl/input_repeat_ctrl.sv
// Keyboard auto-repeat controller for a falling-block game.
// Converts debounced key levels into single-cycle move commands.
// Left/right share one delayed-auto-shift FSM where the newest key wins.
// Soft drop repeats at a fixed rate. Rotate and hard drop fire once per press.
// Keys held through reset or through a disabled period must be released before
// they can produce a command again.
module input_repeat_ctrl #(
    parameter int DAS_CYCLES = 4_000_000,
    parameter int ARR_CYCLES = 1_250_000,
    parameter int SDR_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic key_left,
    input  logic key_right,
    input  logic key_down,
    input  logic key_rot,
    input  logic key_drop,
    output logic mv_left,
    output logic mv_right,
    output logic mv_down,
    output logic mv_rot,
    output logic mv_drop
);

    localparam int H_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int HW    = $clog2(H_MAX);
    localparam int DW    = $clog2(SDR_CYCLES);

    localparam logic [HW-1:0] DAS_LAST = HW'(DAS_CYCLES - 1);
    localparam logic [HW-1:0] ARR_LAST = HW'(ARR_CYCLES - 1);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [DW-1:0] SDR_LAST = DW'(SDR_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE    = DW'(1);

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_DAS    = 2'd1,
        H_REPEAT = 2'd2
    } hstate_t;

    typedef enum logic {
        OWN_LEFT  = 1'b0,
        OWN_RIGHT = 1'b1
    } owner_t;

    // Reset and a disabled game both park every block in its idle state.
    logic clear;
    assign clear = rst | ~enable;

    // Previous-sample registers. They are forced to 1 while cleared so that a
    // key already down must first be seen released.
    logic prev_left, prev_right, prev_down, prev_rot, prev_drop;
    // A horizontal key is "armed" once it has been seen released while
    // enabled. Only an armed key may take ownership on the owner's release.
    logic arm_left, arm_right;

    logic press_left, press_right, press_down, press_rot, press_drop;
    assign press_left  = key_left  & ~prev_left;
    assign press_right = key_right & ~prev_right;
    assign press_down  = key_down  & ~prev_down;
    assign press_rot   = key_rot   & ~prev_rot;
    assign press_drop  = key_drop  & ~prev_drop;

    // Sample key levels for edge detection and track the armed flags.
    always_ff @(posedge clk) begin
        if (clear) begin
            prev_left  <= 1'b1;
            prev_right <= 1'b1;
            prev_down  <= 1'b1;
            prev_rot   <= 1'b1;
            prev_drop  <= 1'b1;
            arm_left   <= 1'b0;
            arm_right  <= 1'b0;
        end else begin
            prev_left  <= key_left;
            prev_right <= key_right;
            prev_down  <= key_down;
            prev_rot   <= key_rot;
            prev_drop  <= key_drop;
            arm_left   <= arm_left  | ~key_left;
            arm_right  <= arm_right | ~key_right;
        end
    end

    hstate_t        hstate;
    owner_t         owner;
    logic [HW-1:0]  hcnt;

    owner_t         other;
    logic           own_key;
    logic           oth_ok;
    logic           oth_press;
    logic [HW-1:0]  h_last;

    // Owner-relative view of the two horizontal keys.
    always_comb begin
        other     = (owner == OWN_LEFT) ? OWN_RIGHT : OWN_LEFT;
        own_key   = (owner == OWN_LEFT) ? key_left : key_right;
        oth_ok    = (owner == OWN_LEFT) ? (key_right & arm_right) : (key_left & arm_left);
        oth_press = (owner == OWN_LEFT) ? press_right : press_left;
        h_last    = (hstate == H_DAS) ? DAS_LAST : ARR_LAST;
    end

    // Horizontal DAS/ARR state machine; left wins a simultaneous press.
    always_ff @(posedge clk) begin
        if (clear) begin
            hstate   <= H_IDLE;
            owner    <= OWN_LEFT;
            hcnt     <= '0;
            mv_left  <= 1'b0;
            mv_right <= 1'b0;
        end else begin
            mv_left  <= 1'b0;
            mv_right <= 1'b0;
            case (hstate)
                H_IDLE: begin
                    hcnt <= '0;
                    if (press_left) begin
                        owner   <= OWN_LEFT;
                        mv_left <= 1'b1;
                        hstate  <= H_DAS;
                    end else if (press_right) begin
                        owner    <= OWN_RIGHT;
                        mv_right <= 1'b1;
                        hstate   <= H_DAS;
                    end
                end
                H_DAS, H_REPEAT: begin
                    if (!own_key && !oth_ok) begin
                        hstate <= H_IDLE;
                        hcnt   <= '0;
                    end else if (!own_key || oth_press) begin
                        // Ownership moves to the other key, which restarts DAS.
                        owner    <= other;
                        mv_left  <= (other == OWN_LEFT);
                        mv_right <= (other == OWN_RIGHT);
                        hcnt     <= '0;
                        hstate   <= H_DAS;
                    end else if (hcnt >= h_last) begin
                        mv_left  <= (owner == OWN_LEFT);
                        mv_right <= (owner == OWN_RIGHT);
                        hcnt     <= '0;
                        hstate   <= H_REPEAT;
                    end else begin
                        hcnt <= hcnt + H_ONE;
                    end
                end
                default: begin
                    hstate <= H_IDLE;
                    hcnt   <= '0;
                end
            endcase
        end
    end

    logic           sd_active;
    logic [DW-1:0]  dcnt;

    // Soft drop: immediate pulse, then a fixed repeat period with no delay stage.
    always_ff @(posedge clk) begin
        if (clear) begin
            sd_active <= 1'b0;
            dcnt      <= '0;
            mv_down   <= 1'b0;
        end else begin
            mv_down <= 1'b0;
            if (press_down) begin
                sd_active <= 1'b1;
                dcnt      <= '0;
                mv_down   <= 1'b1;
            end else if (sd_active) begin
                if (!key_down) begin
                    sd_active <= 1'b0;
                    dcnt      <= '0;
                end else if (dcnt >= SDR_LAST) begin
                    dcnt    <= '0;
                    mv_down <= 1'b1;
                end else begin
                    dcnt <= dcnt + D_ONE;
                end
            end
        end
    end

    // Rotate and hard drop fire once per press and never repeat.
    always_ff @(posedge clk) begin
        if (clear) begin
            mv_rot  <= 1'b0;
            mv_drop <= 1'b0;
        end else begin
            mv_rot  <= press_rot;
            mv_drop <= press_drop;
        end
    end

endmodule

// File: tb/tb_input_repeat_ctrl.sv
// Bench for input_repeat_ctrl with short timing parameters.
// An event-time model predicts every output cycle. Directed scenarios pin
// the exact pulse trains with literal masks. A random phase follows.
module tb_input_repeat_ctrl;

    localparam int DAS   = 10;
    localparam int ARR   = 4;
    localparam int SDR   = 3;
    localparam int OBS_N = 8192;

    // Bit order for keys and commands: {drop, rot, down, right, left}
    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_L    = 5'b00001;
    localparam logic [4:0] K_R    = 5'b00010;
    localparam logic [4:0] K_D    = 5'b00100;
    localparam logic [4:0] K_ROT  = 5'b01000;

    logic clk;
    logic rst;
    logic enable;
    logic key_left, key_right, key_down, key_rot, key_drop;
    logic mv_left, mv_right, mv_down, mv_rot, mv_drop;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [4:0] exp_q[$];
    logic [4:0] obs[OBS_N];

    // Model state: absolute edge numbers at which the next repeat is due
    logic [4:0] m_prev  = 5'b11111;
    logic [1:0] m_arm   = 2'b00;
    int         m_owner = -1;
    int         m_next_h = 0;
    bit         m_dact  = 1'b0;
    int         m_next_d = 0;
    logic [4:0] mk, mpress, me;
    int         moth;

    logic [4:0] ce, cd;
    logic [4:0] rk;
    int         s;

    input_repeat_ctrl #(
        .DAS_CYCLES(DAS),
        .ARR_CYCLES(ARR),
        .SDR_CYCLES(SDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .key_left (key_left),
        .key_right(key_right),
        .key_down (key_down),
        .key_rot  (key_rot),
        .key_drop (key_drop),
        .mv_left  (mv_left),
        .mv_right (mv_right),
        .mv_down  (mv_down),
        .mv_rot   (mv_rot),
        .mv_drop  (mv_drop)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: predicts the commands visible in the cycle after edge cyc
    always @(posedge clk) begin
        mk = {key_drop, key_rot, key_down, key_right, key_left};
        me = 5'b0;
        if (rst || !enable) begin
            m_prev  = 5'b11111;
            m_arm   = 2'b00;
            m_owner = -1;
            m_dact  = 1'b0;
        end else begin
            mpress = mk & ~m_prev;
            if (m_owner < 0) begin
                if (mpress[0]) begin
                    m_owner = 0; me[0] = 1'b1; m_next_h = cyc + DAS;
                end else if (mpress[1]) begin
                    m_owner = 1; me[1] = 1'b1; m_next_h = cyc + DAS;
                end
            end else begin
                moth = 1 - m_owner;
                if (!mk[m_owner] && !(mk[moth] && m_arm[moth])) begin
                    m_owner = -1;
                end else if (!mk[m_owner] || mpress[moth]) begin
                    m_owner = moth; me[moth] = 1'b1; m_next_h = cyc + DAS;
                end else if (cyc == m_next_h) begin
                    me[m_owner] = 1'b1; m_next_h = cyc + ARR;
                end
            end
            if (mpress[2]) begin
                m_dact = 1'b1; me[2] = 1'b1; m_next_d = cyc + SDR;
            end else if (m_dact) begin
                if (!mk[2]) m_dact = 1'b0;
                else if (cyc == m_next_d) begin
                    me[2] = 1'b1; m_next_d = cyc + SDR;
                end
            end
            me[3] = mpress[3];
            me[4] = mpress[4];
            m_arm  = m_arm | ~mk[1:0];
            m_prev = mk;
        end
        exp_q.push_back(me);
        cyc++;
    end

    // Scoreboard: every output cycle is compared against the model
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            cd = {mv_drop, mv_rot, mv_down, mv_right, mv_left};
            if (cyc < OBS_N) obs[cyc] = cd;
            n_cmp++;
            if (cd !== ce) begin
                n_bad++;
                $display("FAIL cycle_outputs at cycle %0d: got %b expected %b", cyc, cd, ce);
            end
        end
    end

    // Driver: apply key levels, then hold them for n clock edges
    task automatic step(input logic [4:0] k, input int n);
        {key_drop, key_rot, key_down, key_right, key_left} = k;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] mask_of(input int b, input int st);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (st + i < OBS_N) m[i] = obs[st + i][b];
        end
        return m;
    endfunction

    task automatic check_mask(input string name, input int b, input int st, input logic [63:0] want);
        logic [63:0] got;
        got = mask_of(b, st);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: pulse mask got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_out(input string name, input int idx, input logic [4:0] want);
        n_cmp++;
        if (obs[idx] !== want) begin
            n_bad++;
            $display("FAIL %s: outputs got %b expected %b", name, obs[idx], want);
        end
    endtask

    // Stimulus sequence
    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        step(K_L | K_R | K_D, 3);
        check_out("reset_outputs", cyc - 1, 5'b00000);
        rst = 1'b0;
        step(K_L | K_R | K_D, 5);
        step(K_NONE, 5);

        // Left held 30 cycles: DAS then ARR train
        s = cyc;
        step(K_L, 30);
        step(K_NONE, 64);
        check_mask("left_hold_train", 0, s, 64'h0000_0000_0888_8802);
        check_mask("left_hold_no_right", 1, s, 64'h0);

        // Right pressed while left is held: newest key wins
        s = cyc;
        step(K_L, 5);
        step(K_L | K_R, 25);
        step(K_NONE, 64);
        check_mask("takeover_left", 0, s, 64'h0000_0000_0000_0002);
        check_mask("takeover_right", 1, s, 64'h0000_0000_1111_0040);

        // Simultaneous press from idle, then left released
        s = cyc;
        step(K_L | K_R, 8);
        step(K_R, 20);
        step(K_NONE, 64);
        check_mask("simul_left", 0, s, 64'h0000_0000_0000_0002);
        check_mask("simul_right", 1, s, 64'h0000_0000_0888_0200);

        // Rotate has no repeat; soft drop repeats without a delay stage
        s = cyc;
        step(K_ROT, 20);
        step(K_NONE, 64);
        check_mask("rot_single", 3, s, 64'h0000_0000_0000_0002);
        s = cyc;
        step(K_D, 10);
        step(K_NONE, 64);
        check_mask("down_train", 2, s, 64'h0000_0000_0000_0492);

        // Right held across reset and disable: needs release and re-press
        step(K_R, 3);
        s = cyc;
        rst = 1'b1;
        step(K_R, 2);
        rst    = 1'b0;
        enable = 1'b0;
        step(K_R, 3);
        enable = 1'b1;
        step(K_R, 10);
        step(K_NONE, 2);
        step(K_R, 4);
        step(K_NONE, 64);
        check_mask("held_through_reset_right", 1, s, 64'h0000_0000_0004_0000);
        check_mask("held_through_reset_left", 0, s, 64'h0);

        // Reset during REPEAT stops the train
        s = cyc;
        step(K_L, 16);
        rst = 1'b1;
        step(K_L, 1);
        rst = 1'b0;
        step(K_L, 10);
        step(K_NONE, 64);
        check_mask("reset_in_repeat_left", 0, s, 64'h0000_0000_0000_8802);
        check_out("reset_in_repeat_next", s + 17, 5'b00000);

        // Random key activity with steady enable
        rk = K_NONE;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 19) == 0) rk[b] = ~rk[b];
            end
            step(rk, 1);
        end

        // Random key activity with enable drops and occasional reset
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 15) == 0) rk[b] = ~rk[b];
            end
            rst    = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 59) != 0);
            step(rk, 1);
        end

        rst    = 1'b0;
        enable = 1'b1;
        step(K_NONE, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_repeat_ctrl.md
INPUT_REPEAT_CTRL -- requirements
Module: input_repeat_ctrl

Interface
REQ-001 SHALL have parameter DAS_CYCLES, default 4_000_000, the delayed-auto-shift hold time in clk cycles (160 ms @ 25 MHz), legal range >= 2.
REQ-002 SHALL have parameter ARR_CYCLES, default 1_250_000, the horizontal auto-repeat period in clk cycles (50 ms), legal range >= 2.
REQ-003 SHALL have parameter SDR_CYCLES, default 1_000_000, the soft-drop repeat period in clk cycles (40 ms), legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single 25 MHz system clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: game accepts moves; while low, all pulse outputs are suppressed.
REQ-007 SHALL have ports key_left, key_right, key_down, key_rot, key_drop, each input, 1 bit: debounced key levels, 1 = pressed.
REQ-008 SHALL have ports mv_left, mv_right, mv_down, mv_rot, mv_drop, each output, 1 bit: registered single-cycle command pulses.

Function
REQ-009 SHALL register all outputs; an output pulse lasts exactly one cycle.
REQ-010 SHALL detect a press as key sampled 1 with its previous-sample register 0, and a release as sampled 0.
REQ-011 SHALL drive mv_rot and mv_drop high for one cycle, in the cycle after the press sample, with no repeat while held.
REQ-012 SHALL implement the horizontal FSM with states IDLE, DAS, REPEAT and an owner flag (LEFT/RIGHT).
REQ-013 SHALL on a horizontal press in cycle T: set owner, pulse mv_<owner> at T+1, clear the counter, and enter DAS.
REQ-014 SHALL in DAS, after DAS_CYCLES cycles held (at T+1+DAS_CYCLES), pulse mv_<owner>, clear the counter, and enter REPEAT.
REQ-015 SHALL in REPEAT pulse mv_<owner> every ARR_CYCLES cycles while the owner key stays held.
REQ-016 SHALL on owner release with the other key not held return to IDLE with no pulse.
REQ-017 SHALL on owner release with the other key held transfer ownership, pulse the new owner next cycle, and restart DAS.
REQ-018 SHALL on a press of the non-owner key while the owner is held transfer ownership to the newer key, with the same behaviour as REQ-013 (last-pressed wins).
REQ-019 SHALL on key_left and key_right pressed in the same cycle from IDLE give ownership to LEFT.
REQ-020 SHALL never assert mv_left and mv_right in the same cycle.
REQ-021 SHALL implement soft drop independently: mv_down at press+1, then every SDR_CYCLES while held, with no DAS stage.
REQ-022 SHALL size each counter to $clog2(max period) bits and saturate/clear it so it never wraps while held.
REQ-023 SHALL while enable is low: force all FSMs to IDLE, clear counters, and suppress pulses.
REQ-024 SHALL require keys held at the enable rise to be released and re-pressed before they generate a pulse.
REQ-025 SHALL allow horizontal, soft-drop, rotate and drop pulses to coincide in one cycle.

Reset
REQ-026 SHALL on rst=1 at a clk edge clear all outputs to 0, all FSMs to IDLE, all counters to 0, and set all previous-sample registers to 1, so that keys held through reset need a release first.
REQ-027 SHALL let rst override enable and keys, and abort any DAS or REPEAT sequence with no pulse in the following cycle.

Verification (DAS_CYCLES=10, ARR_CYCLES=4, SDR_CYCLES=3)
REQ-028 SHALL cover: key_left pressed at cycle 0 and held 30 cycles -> mv_left at cycles 1, 11, 15, 19, 23, 27, and no pulse after release.
REQ-029 SHALL cover: left held, key_right pressed at cycle 5 -> mv_right at cycle 6, 16, 20, ...; no mv_left after cycle 1.
REQ-030 SHALL cover: left and right pressed at the same cycle 0 -> mv_left at cycle 1 only direction; left released at cycle 8 -> mv_right at cycle 9, then DAS restarts.
REQ-031 SHALL cover: key_rot held 20 cycles -> exactly one mv_rot at cycle 1; key_down held 10 cycles -> mv_down at cycles 1, 4, 7, 10.
REQ-032 SHALL cover: key_right held across rst and enable low->high -> no pulse until release and re-press; re-press at T -> mv_right at T+1.
REQ-033 SHALL cover: rst asserted during REPEAT -> all outputs 0 next cycle; the repeat train stops.
